// File: rtl/htif_mem_arb.sv
// Shares one memory request/response port between HTIF (requester 0) and core requesters.
// Round-robin arbitration with optional HTIF priority, per-requester read tracking, tag routing.
module htif_mem_arb #(
   parameter int unsigned NREQ         = 4,
   parameter int unsigned ID_BITS      = 2,
   parameter int unsigned REQ_TAG_BITS = 3,
   parameter int unsigned MAX_OUT      = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            htif_prio,
   input  logic [NREQ-1:0]                 req_val,
   output logic [NREQ-1:0]                 req_rdy,
   input  logic [NREQ-1:0]                 req_op,
   input  logic [32*NREQ-1:0]              req_addr,
   input  logic [128*NREQ-1:0]             req_data,
   input  logic [REQ_TAG_BITS*NREQ-1:0]    req_tag,
   output logic                            mem_req_val,
   input  logic                            mem_req_rdy,
   output logic                            mem_req_op,
   output logic [31:0]                     mem_req_addr,
   output logic [127:0]                    mem_req_data,
   output logic [ID_BITS+REQ_TAG_BITS-1:0] mem_req_tag,
   input  logic                            mem_resp_val,
   input  logic [127:0]                    mem_resp_data,
   input  logic [ID_BITS+REQ_TAG_BITS-1:0] mem_resp_tag,
   output logic [NREQ-1:0]                 resp_val,
   output logic [127:0]                    resp_data,
   output logic [REQ_TAG_BITS-1:0]         resp_tag,
   output logic                            error
);

   localparam int unsigned TagBits = ID_BITS + REQ_TAG_BITS;
   localparam logic [2:0]  MaxOut  = 3'(MAX_OUT);

   logic                 full_q;
   logic                 op_q;
   logic [31:0]          addr_q;
   logic [127:0]         data_q;
   logic [TagBits-1:0]   tag_q;
   logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
   logic [2:0]           outstanding_q [NREQ];
   logic [2:0]           outstanding_d [NREQ];
   logic                 error_q;

   logic [NREQ-1:0]      elig;
   logic                 win_any;
   logic [ID_BITS-1:0]   win;
   logic [ID_BITS-1:0]   scan_idx;
   logic                 can_accept, accept;
   logic [ID_BITS-1:0]   resp_id;
   logic                 id_valid, resp_ok;
   logic [NREQ-1:0]      cnt_inc, cnt_dec;

   // Writes never produce a response, so they bypass the outstanding limit.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = req_val[i] && (req_op[i] || (outstanding_q[i] < MaxOut));
      end
   end

   always_comb begin
      win_any  = 1'b0;
      win      = '0;
      scan_idx = '0;
      if (htif_prio && elig[0]) begin
         win_any = 1'b1;
      end else begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = ID_BITS'((32'(rr_ptr_q) + k) % NREQ);
            if (!win_any && elig[scan_idx]) begin
               win_any = 1'b1;
               win     = scan_idx;
            end
         end
      end
   end

   assign can_accept = !full_q || mem_req_rdy;
   assign accept     = win_any && can_accept;
   assign rr_ptr_d   = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_rdy[i] = accept && (win == ID_BITS'(i));
      end
   end

   assign resp_id  = mem_resp_tag[TagBits-1:REQ_TAG_BITS];
   assign id_valid = 32'(resp_id) < NREQ;
   assign resp_ok  = mem_resp_val && id_valid && (outstanding_q[resp_id] != '0);

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         cnt_inc[i] = accept && !req_op[win] && (win == ID_BITS'(i));
         cnt_dec[i] = resp_ok && (resp_id == ID_BITS'(i));
         resp_val[i] = cnt_dec[i];
         unique case ({cnt_inc[i], cnt_dec[i]})
            2'b10:   outstanding_d[i] = outstanding_q[i] + 3'd1;
            2'b01:   outstanding_d[i] = outstanding_q[i] - 3'd1;
            default: outstanding_d[i] = outstanding_q[i];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q   <= 1'b0;
         op_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         tag_q    <= '0;
         rr_ptr_q <= '0;
         error_q  <= 1'b0;
         for (int i = 0; i < NREQ; i++) outstanding_q[i] <= '0;
      end else begin
         full_q  <= accept || (full_q && !mem_req_rdy);
         error_q <= error_q || (mem_resp_val && !resp_ok);
         // Register only loads on accept, so a held request never changes.
         if (accept) begin
            op_q     <= req_op[win];
            addr_q   <= req_addr[win*32 +: 32];
            data_q   <= req_data[win*128 +: 128];
            tag_q    <= {win, req_tag[win*REQ_TAG_BITS +: REQ_TAG_BITS]};
            rr_ptr_q <= rr_ptr_d;
         end
         for (int i = 0; i < NREQ; i++) outstanding_q[i] <= outstanding_d[i];
      end
   end

   assign mem_req_val  = full_q;
   assign mem_req_op   = op_q;
   assign mem_req_addr = addr_q;
   assign mem_req_data = data_q;
   assign mem_req_tag  = tag_q;
   assign resp_data    = mem_resp_data;
   assign resp_tag     = mem_resp_tag[REQ_TAG_BITS-1:0];
   assign error        = error_q;

endmodule

// File: tb/tb_htif_mem_arb.sv
// Scoreboard bench for htif_mem_arb: stimulus pushes expected memory requests and responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_htif_mem_arb;

   logic         clk, rst_n, htif_prio;
   logic [3:0]   req_val, req_rdy, req_op;
   logic [127:0] req_addr;
   logic [511:0] req_data;
   logic [11:0]  req_tag;
   logic         mem_req_val, mem_req_rdy, mem_req_op;
   logic [31:0]  mem_req_addr;
   logic [127:0] mem_req_data;
   logic [4:0]   mem_req_tag;
   logic         mem_resp_val;
   logic [127:0] mem_resp_data;
   logic [4:0]   mem_resp_tag;
   logic [3:0]   resp_val;
   logic [127:0] resp_data;
   logic [2:0]   resp_tag;
   logic         error;

   typedef struct packed {
      logic         op;
      logic [31:0]  addr;
      logic [127:0] data;
      logic [4:0]   tag;
   } mreq_t;

   typedef struct packed {
      logic [3:0]   vec;
      logic [127:0] data;
      logic [2:0]   tag;
   } resp_t;

   mreq_t mem_q[$];
   resp_t resp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;

   htif_mem_arb #(.NREQ(4), .ID_BITS(2), .REQ_TAG_BITS(3), .MAX_OUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .htif_prio(htif_prio),
      .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_addr(req_addr),
      .req_data(req_data), .req_tag(req_tag),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_op(mem_req_op),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
      .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag),
      .resp_val(resp_val), .resp_data(resp_data), .resp_tag(resp_tag), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] mk_data(input logic [31:0] a);
      return {a, ~a, a ^ 32'h5a5a_5a5a, a + 32'd7};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic op, input logic [31:0] a,
                          input logic [2:0] t);
      req_val[i]             = v;
      req_op[i]              = op;
      req_addr[32*i +: 32]   = a;
      req_data[128*i +: 128] = mk_data(a);
      req_tag[3*i +: 3]      = t;
   endtask

   // Compares req_rdy with the hand-computed grant and queues the granted request.
   task automatic expect_rdy(input logic [3:0] exp, input string name);
      mreq_t e;
      #1;
      check(name, 256'(req_rdy), 256'(exp));
      for (int w = 0; w < 4; w++) begin
         if (exp[w]) begin
            e.op   = req_op[w];
            e.addr = req_addr[32*w +: 32];
            e.data = req_data[128*w +: 128];
            e.tag  = {2'(w), req_tag[3*w +: 3]};
            mem_q.push_back(e);
         end
      end
   endtask

   task automatic send_resp(input logic [1:0] id, input logic [2:0] t, input logic [127:0] d,
                            input logic [3:0] exp_vec);
      resp_t r;
      mem_resp_val  = 1'b1;
      mem_resp_tag  = {id, t};
      mem_resp_data = d;
      if (exp_vec != 4'b0) begin
         r.vec  = exp_vec;
         r.data = d;
         r.tag  = t;
         resp_q.push_back(r);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         req_val      = '0;
         mem_resp_val = 1'b0;
         mem_req_rdy  = 1'b1;
         htif_prio    = 1'b0;
      end
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      mreq_t e;
      resp_t r;
      if (rst_n) begin
         if (mem_req_val && mem_req_rdy) begin
            if (mem_q.size() == 0) begin
               check("mem_req_unexpected", 256'(mem_req_tag), 256'h1ff);
            end else begin
               e = mem_q.pop_front();
               check("mem_req", 256'({mem_req_op, mem_req_addr, mem_req_data, mem_req_tag}),
                     256'(e));
            end
         end
         if (resp_val != 4'b0) begin
            if (resp_q.size() == 0) begin
               check("resp_unexpected", 256'(resp_val), 256'h0);
            end else begin
               r = resp_q.pop_front();
               check("resp", 256'({resp_val, resp_data, resp_tag}), 256'(r));
            end
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      htif_prio     = 1'b0;
      req_val       = '0;
      req_op        = '0;
      req_addr      = '0;
      req_data      = '0;
      req_tag       = '0;
      mem_req_rdy   = 1'b1;
      mem_resp_val  = 1'b0;
      mem_resp_data = '0;
      mem_resp_tag  = '0;
      #2;
      check("rst_mem_req_val", 256'(mem_req_val), 256'(0));
      check("rst_req_rdy", 256'(req_rdy), 256'(0));
      check("rst_resp_val", 256'(resp_val), 256'(0));
      check("rst_error", 256'(error), 256'(0));
      tick();
      rst_n = 1'b1;

      // Single HTIF read, then its response
      tick();
      set_req(0, 1'b1, 1'b0, 32'h0000_1000, 3'd5);
      expect_rdy(4'b0001, "htif_read_grant");
      tick();
      req_val = '0;
      expect_rdy(4'b0000, "htif_read_idle");
      #1;
      check("htif_mem_req_val", 256'(mem_req_val), 256'(1));
      check("htif_mem_req_tag", 256'(mem_req_tag), 256'({2'd0, 3'd5}));
      tick();
      send_resp(2'd0, 3'd5, {4{32'hcafe_0001}}, 4'b0001);
      idle(2);

      // Round-robin with all four requesters valid
      do_reset();
      set_req(0, 1'b1, 1'b0, 32'h0000_2000, 3'd1);
      set_req(1, 1'b1, 1'b0, 32'h0000_2100, 3'd2);
      set_req(2, 1'b1, 1'b0, 32'h0000_2200, 3'd3);
      set_req(3, 1'b1, 1'b0, 32'h0000_2300, 3'd4);
      expect_rdy(4'b0001, "rr_0");
      tick(); expect_rdy(4'b0010, "rr_1");
      tick(); expect_rdy(4'b0100, "rr_2");
      tick(); expect_rdy(4'b1000, "rr_3");
      tick(); expect_rdy(4'b0001, "rr_wrap");
      idle(3);

      // HTIF strict priority starves requester 2 until priority drops
      do_reset();
      htif_prio = 1'b1;
      set_req(0, 1'b1, 1'b0, 32'h0000_3000, 3'd6);
      set_req(2, 1'b1, 1'b0, 32'h0000_3200, 3'd7);
      expect_rdy(4'b0001, "prio_0");
      tick(); expect_rdy(4'b0001, "prio_1");
      tick(); expect_rdy(4'b0001, "prio_2");
      tick();
      htif_prio = 1'b0;
      expect_rdy(4'b0100, "prio_drop");
      idle(3);

      // Backpressure: held request stays stable, new request accepted on drain
      do_reset();
      mem_req_rdy = 1'b0;
      set_req(3, 1'b1, 1'b0, 32'h0000_4300, 3'd2);
      expect_rdy(4'b1000, "hold_first");
      tick();
      set_req(3, 1'b0, 1'b1, 32'hdead_beef, 3'd0);
      set_req(1, 1'b1, 1'b0, 32'h0000_4100, 3'd1);
      for (int k = 0; k < 5; k++) begin
         expect_rdy(4'b0000, "hold_rdy");
         check("hold_val", 256'(mem_req_val), 256'(1));
         check("hold_addr", 256'(mem_req_addr), 256'(32'h0000_4300));
         check("hold_tag", 256'(mem_req_tag), 256'({2'd3, 3'd2}));
         tick();
      end
      mem_req_rdy = 1'b1;
      expect_rdy(4'b0010, "hold_release");
      idle(3);

      // Outstanding limit for requester 1
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_req(1, 1'b1, 1'b0, 32'h0000_5100 + 32'(k), 3'(k));
         expect_rdy(4'b0010, "limit_fill");
         tick();
      end
      set_req(1, 1'b1, 1'b0, 32'h0000_5180, 3'd4);
      set_req(3, 1'b1, 1'b0, 32'h0000_5300, 3'd5);
      expect_rdy(4'b1000, "limit_pass_to_3");
      tick();
      set_req(3, 1'b0, 1'b0, 32'h0, 3'd0);
      set_req(1, 1'b1, 1'b1, 32'h0000_51f0, 3'd6);
      expect_rdy(4'b0010, "limit_write_ok");
      tick();
      set_req(1, 1'b1, 1'b0, 32'h0000_5190, 3'd7);
      expect_rdy(4'b0000, "limit_read_blocked");
      tick();
      req_val = '0;
      send_resp(2'd1, 3'd3, {4{32'h1234_5678}}, 4'b0010);
      expect_rdy(4'b0000, "limit_resp_cycle");
      tick();
      mem_resp_val = 1'b0;
      set_req(1, 1'b1, 1'b0, 32'h0000_51a0, 3'd1);
      expect_rdy(4'b0010, "limit_unblocked");
      idle(3);

      // Orphan response after reset: dropped and flagged, error sticky until reset
      do_reset();
      send_resp(2'd1, 3'd2, {4{32'h0bad_0bad}}, 4'b0000);
      #1;
      check("orphan_resp_val", 256'(resp_val), 256'(0));
      tick();
      mem_resp_val = 1'b0;
      check("orphan_error", 256'(error), 256'(1));
      for (int k = 0; k < 3; k++) begin
         tick();
         check("error_sticky", 256'(error), 256'(1));
      end
      rst_n = 1'b0;
      #1;
      check("error_cleared", 256'(error), 256'(0));
      tick();
      rst_n = 1'b1;
      idle(2);

      check("mem_q_drained", 256'(mem_q.size()), 256'(0));
      check("resp_q_drained", 256'(resp_q.size()), 256'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
